// File: rtl/fifo_burst_sched.sv
// fifo_burst_sched
//   Drains a show-ahead FIFO into an Avalon-MM write master as fixed-address
//   bursts. A burst launches when a full burst is buffered, when flush is
//   high, or when a partial fill has sat untouched for TIMEOUT cycles.
//   This block is the FIFO's only reader.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   fifo_empty/full/usedw/q     FIFO status and show-ahead head word
//   fifo_rdreq                  pop strobe, one per accepted beat
//   flush                       level request to drain any fill
//   cfg_base_load, cfg_base     load the word address counter (IDLE only)
//   avm_*                       Avalon-MM burst write master
//   busy                        high while a burst is in progress
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a launch condition, running the stale-fill timer
// BURST | presenting beats; leaves after the last accepted beat
module fifo_burst_sched #(
   parameter int WIDTH   = 32,
   parameter int WIDTHU  = 4,
   parameter int ADDRW   = 24,
   parameter int BURST   = 4,
   parameter int BCW     = 3,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   input  logic              fifo_full,
   input  logic [WIDTHU-1:0] fifo_usedw,
   input  logic [WIDTH-1:0]  fifo_q,
   output logic              fifo_rdreq,
   input  logic              flush,
   input  logic              cfg_base_load,
   input  logic [ADDRW-1:0]  cfg_base,
   output logic [ADDRW-1:0]  avm_address,
   output logic              avm_write,
   output logic [WIDTH-1:0]  avm_writedata,
   output logic [BCW-1:0]    avm_burstcount,
   input  logic              avm_waitrequest,
   output logic              busy
);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   localparam int              DEPTH     = 2**WIDTHU;
   localparam logic [WIDTHU:0] DEPTH_C   = (WIDTHU+1)'(DEPTH);
   localparam logic [WIDTHU:0] BURST_C   = (WIDTHU+1)'(BURST);
   localparam logic [7:0]      TIMEOUT_C = 8'(TIMEOUT);

   state_t           state_q, state_d;
   logic [ADDRW-1:0] addr_q, addr_d;
   logic [7:0]       timer_q, timer_d;
   logic [BCW-1:0]   len_q, len_d;
   logic [BCW-1:0]   beats_q, beats_d;
   logic [WIDTHU:0]  cnt;
   logic             accept;

   // usedw wraps to 0 when the FIFO is full, so full restores the top bit
   assign cnt    = fifo_full ? DEPTH_C : {1'b0, fifo_usedw};
   assign accept = (state_q == S_BURST) && !avm_waitrequest;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         timer_q <= '0;
         len_q   <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         timer_q <= timer_d;
         len_q   <= len_d;
         beats_q <= beats_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      timer_d = timer_q;
      len_d   = len_q;
      beats_d = beats_q;
      case (state_q)
         S_IDLE: begin
            // a load coinciding with a launch is the address that burst uses
            if (cfg_base_load) addr_d = cfg_base;
            if (cnt >= BURST_C) begin
               state_d = S_BURST;
               len_d   = BCW'(BURST);
               beats_d = BCW'(BURST);
               timer_d = '0;
            end else if (cnt != '0 && (flush || timer_q == TIMEOUT_C)) begin
               state_d = S_BURST;
               len_d   = BCW'(cnt);
               beats_d = BCW'(cnt);
               timer_d = '0;
            end else if (cnt == '0) begin
               timer_d = '0;
            end else if (timer_q != TIMEOUT_C) begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_BURST: begin
            if (accept) begin
               beats_d = beats_q - 1'b1;
               if (beats_q == BCW'(1)) begin
                  state_d = S_IDLE;
                  addr_d  = addr_q + ADDRW'(len_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign avm_write      = (state_q == S_BURST);
   assign busy           = (state_q == S_BURST);
   assign avm_address    = addr_q;
   assign avm_burstcount = (state_q == S_BURST) ? len_q : '0;
   assign avm_writedata  = fifo_q;
   assign fifo_rdreq     = accept;

   // the launch rule guarantees enough words, so an empty pop means a second reader
   a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_rdreq && fifo_empty));

endmodule

// File: tb/tb_fifo_burst_sched.sv
module tb_fifo_burst_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_rst_n = 1'b0;
   logic        fifo_empty, fifo_full, fifo_rdreq;
   logic [3:0]  fifo_usedw;
   logic [31:0] fifo_q;
   logic        flush = 1'b0;
   logic        cfg_base_load = 1'b0;
   logic [23:0] cfg_base = '0;
   logic [23:0] avm_address;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [2:0]  avm_burstcount;
   logic        avm_waitrequest = 1'b0;
   logic        busy;

   logic        push = 1'b0;
   logic [31:0] push_data = '0;

   int total = 0;
   int bad = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   fifo_burst_sched dut (
      .clk(clk), .rst_n(rst_n),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_usedw(fifo_usedw),
      .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
      .flush(flush), .cfg_base_load(cfg_base_load), .cfg_base(cfg_base),
      .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest), .busy(busy)
   );

   // show-ahead FIFO, depth 16, with its own reset
   logic [31:0] fmem [16];
   logic [3:0]  wp, rp;
   int          fcount;

   always @(posedge clk or negedge fifo_rst_n) begin
      if (!fifo_rst_n) begin
         wp <= '0;
         rp <= '0;
         fcount <= 0;
      end else begin
         if (push) begin
            fmem[wp] <= push_data;
            wp <= wp + 4'd1;
         end
         if (fifo_rdreq) rp <= rp + 4'd1;
         fcount <= fcount + (push ? 1 : 0) - (fifo_rdreq ? 1 : 0);
      end
   end

   assign fifo_usedw = 4'(fcount);
   assign fifo_full  = (fcount == 16);
   assign fifo_empty = (fcount == 0);
   assign fifo_q     = fmem[rp];

   task automatic push_words(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         push = 1'b1;
         push_data = base + 32'(i);
         sb.push_back(base + 32'(i));
         @(posedge clk);
         @(negedge clk);
      end
      push = 1'b0;
   endtask

   task automatic load_base(input logic [23:0] a);
      cfg_base = a;
      cfg_base_load = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cfg_base_load = 1'b0;
   endtask

   task automatic run_burst(input logic [23:0] exp_addr, input int len,
                            input int st_lo, input int st_hi);
      int n, c, b, pops;
      logic [31:0] exp_d;
      logic [23:0] nxt;
      n = 0;
      while (!avm_write && n < 300) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      total++;
      if (avm_write !== 1'b1) begin
         $display("FAIL burst_start: avm_write=%0b required 1", avm_write);
         bad++;
         return;
      end
      b = 0; c = 0; pops = 0;
      while (b < len && c < 64) begin
         c++;
         avm_waitrequest = (st_lo != 0 && c >= st_lo && c <= st_hi);
         #1;
         exp_d = (sb.size() > 0) ? sb[0] : 32'hDEAD_BEEF;
         total++;
         if (avm_write !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL beat_write: write=%0b busy=%0b required 1/1", avm_write, busy);
            bad++;
         end
         total++;
         if (avm_address !== exp_addr) begin
            $display("FAIL beat_addr: got %h required %h", avm_address, exp_addr);
            bad++;
         end
         total++;
         if (avm_burstcount !== 3'(len)) begin
            $display("FAIL beat_bcount: got %0d required %0d", avm_burstcount, len);
            bad++;
         end
         total++;
         if (avm_writedata !== exp_d) begin
            $display("FAIL beat_data: got %h required %h", avm_writedata, exp_d);
            bad++;
         end
         total++;
         if (fifo_rdreq !== !avm_waitrequest) begin
            $display("FAIL beat_rdreq: got %0b required %0b", fifo_rdreq, !avm_waitrequest);
            bad++;
         end
         if (!avm_waitrequest) begin
            b++;
            if (sb.size() > 0) void'(sb.pop_front());
         end
         if (fifo_rdreq) pops++;
         @(posedge clk);
         @(negedge clk);
      end
      avm_waitrequest = 1'b0;
      nxt = exp_addr + 24'(len);
      total++;
      if (pops !== len) begin
         $display("FAIL burst_pops: got %0d required %0d", pops, len);
         bad++;
      end
      total++;
      if (avm_write !== 1'b0) begin
         $display("FAIL burst_gap: avm_write=%0b required 0", avm_write);
         bad++;
      end
      total++;
      if (avm_address !== nxt) begin
         $display("FAIL burst_next_addr: got %h required %h", avm_address, nxt);
         bad++;
      end
   endtask

   task automatic check_idle(input string nm, input logic [23:0] exp_addr);
      total++;
      if (avm_write !== 1'b0 || fifo_rdreq !== 1'b0 || busy !== 1'b0 ||
          avm_burstcount !== 3'd0 || avm_address !== exp_addr) begin
         $display("FAIL %s: write=%0b rdreq=%0b busy=%0b bcount=%0d addr=%h required 0/0/0/0/%h",
                  nm, avm_write, fifo_rdreq, busy, avm_burstcount, avm_address, exp_addr);
         bad++;
      end
   endtask

   task automatic fill_in_reset(input int n, input logic [31:0] base);
      rst_n = 1'b0;
      push_words(n, base);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      check_idle("reset_hold", 24'h0);
      fifo_rst_n = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_idle("reset_idle", 24'h0);
      end
   endtask

   task automatic test_full_burst;
      load_base(24'h000100);
      push_words(4, 32'hA0);
      run_burst(24'h000100, 4, 0, 0);
   endtask

   task automatic test_stall;
      push_words(4, 32'hB0);
      run_burst(24'h000104, 4, 2, 4);
   endtask

   task automatic test_timeout;
      int n;
      push_words(2, 32'hC0);
      n = 2;
      while (!avm_write && n < 200) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      total++;
      if (n !== 66) begin
         $display("FAIL timeout_latency: launch edge %0d required 66", n);
         bad++;
      end
      run_burst(24'h000108, 2, 0, 0);
   endtask

   task automatic test_flush_full;
      fill_in_reset(16, 32'hD0);
      total++;
      if (fifo_full !== 1'b1 || fifo_usedw !== 4'd0) begin
         $display("FAIL flush_fill: full=%0b usedw=%0d required 1/0", fifo_full, fifo_usedw);
         bad++;
      end
      flush = 1'b1;
      for (int k = 0; k < 4; k++) run_burst(24'(4 * k), 4, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_idle("flush_full_after", 24'h000010);
      end
      flush = 1'b0;
      total++;
      if (fifo_empty !== 1'b1) begin
         $display("FAIL flush_empty: empty=%0b required 1", fifo_empty);
         bad++;
      end
   endtask

   task automatic test_flush_partial;
      fill_in_reset(6, 32'hE0);
      flush = 1'b1;
      run_burst(24'h000000, 4, 0, 0);
      run_burst(24'h000004, 2, 0, 0);
      flush = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_idle("flush_partial_after", 24'h000006);
   endtask

   task automatic test_addr_wrap;
      load_base(24'hFFFFFE);
      push_words(4, 32'hF0);
      run_burst(24'hFFFFFE, 4, 0, 0);
   endtask

   task automatic test_reset_mid;
      int n;
      load_base(24'h000040);
      push_words(4, 32'h50);
      n = 0;
      while (!avm_write && n < 50) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      total++;
      if (avm_write !== 1'b1) begin
         $display("FAIL mid_start: avm_write=%0b required 1", avm_write);
         bad++;
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle("mid_async_drop", 24'h0);
      fifo_rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      fifo_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_idle("mid_after_release", 24'h0);
      end
   endtask

   initial begin
      test_reset();
      test_full_burst();
      test_stall();
      test_timeout();
      test_flush_full();
      test_flush_partial();
      test_addr_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

endmodule
